// File: rtl/sap3_clk_pkg.sv
// Shared types and defaults for the SAP-3 CPU clock controller.
package sap3_clk_pkg;

    typedef enum logic [1:0] {
        STEP_IDLE  = 2'd0,
        STEP_ARMED = 2'd1,
        RUN        = 2'd2,
        HALTED     = 2'd3
    } clk_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int CE_CNT_W_DEF        = 16;

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Synchronises a raw pushbutton, debounces it and emits a one-cycle press pulse
// on each rising edge of the debounced level.
module btn_debounce
    import sap3_clk_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_s;
    logic             btn_db;
    logic             btn_db_q;
    logic [CNT_W-1:0] cnt;

    // A change of sync_s back to btn_db also lands in the equal branch, so the
    // counter restarts on any glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_s    <= 1'b0;
            btn_db    <= 1'b0;
            btn_db_q  <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= btn_i;
            sync_s    <= sync_meta;
            btn_db_q  <= btn_db;
            if (sync_s == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                btn_db <= sync_s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press_o = btn_db & ~btn_db_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable generator: turns the divided clock level into single-cycle
// enables under free-run, single-step and sticky HLT control.
module cpu_clk_ctrl
    import sap3_clk_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CE_CNT_W        = CE_CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                div_clk_i,
    input  logic                run_i,
    input  logic                step_btn_i,
    input  logic                hlt_i,
    output logic                cpu_ce_o,
    output logic                halted_o,
    output logic                run_mode_o,
    output logic                step_pending_o,
    output logic [CE_CNT_W-1:0] ce_count_o
);

    clk_state_t state_q;
    clk_state_t state_d;
    logic       ce_d;
    logic       div_clk_q;
    logic       tick;
    logic       run_meta;
    logic       run_s;
    logic       press;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (step_btn_i),
        .press_o(press)
    );

    // div_clk_i comes from the divider in this same clock domain, so only a
    // delay flop is needed for edge detection.
    assign tick = div_clk_i & ~div_clk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_clk_q  <= 1'b0;
            run_meta   <= 1'b0;
            run_s      <= 1'b0;
            state_q    <= STEP_IDLE;
            cpu_ce_o   <= 1'b0;
            ce_count_o <= '0;
        end else begin
            div_clk_q <= div_clk_i;
            run_meta  <= run_i;
            run_s     <= run_meta;
            state_q   <= state_d;
            cpu_ce_o  <= ce_d;
            if (ce_d) begin
                ce_count_o <= ce_count_o + CE_CNT_W'(1);
            end
        end
    end

    // HLT overrides everything, including a tick that would issue an enable.
    always_comb begin
        state_d = state_q;
        ce_d    = 1'b0;
        if (hlt_i) begin
            state_d = HALTED;
        end else begin
            case (state_q)
                STEP_IDLE: begin
                    if (run_s) begin
                        state_d = RUN;
                    end else if (press) begin
                        state_d = STEP_ARMED;
                    end
                end
                STEP_ARMED: begin
                    if (run_s) begin
                        state_d = RUN;
                    end else if (tick) begin
                        ce_d    = 1'b1;
                        state_d = STEP_IDLE;
                    end
                end
                RUN: begin
                    if (!run_s) begin
                        state_d = STEP_IDLE;
                    end else if (tick) begin
                        ce_d = 1'b1;
                    end
                end
                default: state_d = HALTED;
            endcase
        end
    end

    assign halted_o       = (state_q == HALTED);
    assign run_mode_o     = (state_q == RUN);
    assign step_pending_o = (state_q == STEP_ARMED);

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: a behavioural reference predicts each
// enable and the scoreboard matches it against the DUT pulse by pulse.
module tb_cpu_clk_ctrl;

    localparam int DB = 4;
    localparam int W  = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_HALT  = 3;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         div_clk_i  = 1'b0;
    logic         run_i      = 1'b0;
    logic         step_btn_i = 1'b0;
    logic         hlt_i      = 1'b0;
    logic         cpu_ce_o;
    logic         halted_o;
    logic         run_mode_o;
    logic         step_pending_o;
    logic [W-1:0] ce_count_o;

    cpu_clk_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CE_CNT_W       (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .div_clk_i     (div_clk_i),
        .run_i         (run_i),
        .step_btn_i    (step_btn_i),
        .hlt_i         (hlt_i),
        .cpu_ce_o      (cpu_ce_o),
        .halted_o      (halted_o),
        .run_mode_o    (run_mode_o),
        .step_pending_o(step_pending_o),
        .ce_count_o    (ce_count_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // divide-by-4 source: phases 0,1 low, phases 2,3 high
    logic [1:0] div_phase = 2'd0;
    logic       div_en    = 1'b1;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (div_en) div_phase = div_phase + 2'd1;
            div_clk_i = div_phase[1];
        end
    endtask

    task automatic wait_phase(input logic [1:0] ph);
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            if (div_phase == ph) break;
        end
        check("phase_wait", 32'(div_phase), 32'(ph));
    endtask

    task automatic hold_btn(input logic v, input int n);
        step_btn_i = v;
        cycles(n);
    endtask

    // reference model and scoreboard
    logic [W-1:0] exp_q[$];
    int           m_mode    = M_IDLE;
    logic         m_div_q   = 1'b0;
    logic         m_run_m   = 1'b0;
    logic         m_run_s   = 1'b0;
    logic         m_btn_m   = 1'b0;
    logic         m_btn_s   = 1'b0;
    logic         m_db      = 1'b0;
    logic         m_press   = 1'b0;
    logic         m_tick    = 1'b0;
    int           m_run_len = 0;
    logic [W-1:0] m_count   = '0;

    task automatic issue_ce();
        m_count = m_count + W'(1);
        exp_q.push_back(m_count);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_div_q = 1'b0; m_run_m = 1'b0; m_run_s = 1'b0;
            m_btn_m = 1'b0; m_btn_s = 1'b0; m_db = 1'b0; m_press = 1'b0;
            m_run_len = 0; m_count = '0;
            exp_q.delete();
        end else begin
            m_tick = div_clk_i && !m_div_q;
            if (hlt_i) m_mode = M_HALT;
            else if (m_mode == M_IDLE) begin
                if (m_run_s) m_mode = M_RUN;
                else if (m_press) m_mode = M_ARMED;
            end else if (m_mode == M_ARMED) begin
                if (m_run_s) m_mode = M_RUN;
                else if (m_tick) begin issue_ce(); m_mode = M_IDLE; end
            end else if (m_mode == M_RUN) begin
                if (!m_run_s) m_mode = M_IDLE;
                else if (m_tick) issue_ce();
            end
            m_div_q = div_clk_i;
            m_run_s = m_run_m;
            m_run_m = run_i;
            m_press = 1'b0;
            if (m_btn_s != m_db) begin
                m_run_len++;
                if (m_run_len == DB) begin
                    m_db      = m_btn_s;
                    m_run_len = 0;
                    m_press   = m_db;
                end
            end else begin
                m_run_len = 0;
            end
            m_btn_s = m_btn_m;
            m_btn_m = step_btn_i;
        end
    end

    logic         chk_en   = 1'b0;
    logic         saw_wrap = 1'b0;
    logic [W-1:0] prev_cnt = '0;
    logic [W-1:0] exp_cnt;

    always @(negedge clk) begin
        if (chk_en) begin
            check("ce_pulse", 32'(cpu_ce_o), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                exp_cnt = exp_q.pop_front();
                check("ce_count_at_ce", 32'(ce_count_o), 32'(exp_cnt));
            end
            check("ce_count", 32'(ce_count_o), 32'(m_count));
            check("halted", 32'(halted_o), 32'(m_mode == M_HALT));
            check("run_mode", 32'(run_mode_o), 32'(m_mode == M_RUN));
            check("step_pending", 32'(step_pending_o), 32'(m_mode == M_ARMED));
            if (cpu_ce_o && ce_count_o == '0 && prev_cnt == '1) saw_wrap = 1'b1;
            prev_cnt = ce_count_o;
        end
    end

    int h_cnt;

    initial begin
        // free-run from reset
        run_i = 1'b1;
        cycles(3);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        cycles(3);
        check("run_by_cycle3", 32'(run_mode_o), 32'd1);
        check("no_ce_before_run", 32'(ce_count_o), 32'd0);
        cycles(37);

        // single step with bounce
        rst_n = 1'b0; run_i = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        hold_btn(1'b1, 1); hold_btn(1'b0, 1); hold_btn(1'b1, 10);
        cycles(6);
        check("step1_count", 32'(ce_count_o), 32'd1);
        hold_btn(1'b0, 10);
        hold_btn(1'b1, 16);
        check("step2_count", 32'(ce_count_o), 32'd2);
        hold_btn(1'b0, 10);

        // double press while armed, divider paused
        div_en = 1'b0;
        hold_btn(1'b1, 10); hold_btn(1'b0, 10);
        hold_btn(1'b1, 10); hold_btn(1'b0, 10);
        check("dbl_armed", 32'(step_pending_o), 32'd1);
        div_en = 1'b1;
        cycles(8);
        check("dbl_count", 32'(ce_count_o), 32'd3);

        // mode switch out of STEP_ARMED discards the step
        div_en = 1'b0;
        hold_btn(1'b1, 10); hold_btn(1'b0, 2);
        check("arm_before_run", 32'(step_pending_o), 32'd1);
        run_i = 1'b1;
        cycles(3);
        check("armed_to_run", 32'(run_mode_o), 32'd1);
        check("armed_discard", 32'(ce_count_o), 32'd3);
        div_en = 1'b1;
        cycles(20);
        wait_phase(2'd0);
        run_i = 1'b0;
        cycles(3);
        check("drop_tick_div_hi", 32'(div_clk_i), 32'd1);
        check("drop_tick_no_ce", 32'(cpu_ce_o), 32'd0);
        cycles(6);
        check("drop_idle", 32'(run_mode_o), 32'd0);

        // HLT wins over a same-cycle tick and is sticky
        run_i = 1'b1;
        cycles(6);
        wait_phase(2'd2);
        hlt_i = 1'b1;
        cycles(1);
        hlt_i = 1'b0;
        check("hlt_no_ce", 32'(cpu_ce_o), 32'd0);
        check("hlt_halted", 32'(halted_o), 32'd1);
        h_cnt = int'(m_count);
        repeat (20) begin
            run_i      = 1'($urandom_range(0, 1));
            step_btn_i = 1'($urandom_range(0, 1));
            cycles(1);
        end
        check("hlt_count_hold", 32'(ce_count_o), 32'(h_cnt));
        check("hlt_sticky", 32'(halted_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_halted", 32'(halted_o), 32'd0);
        check("rst_count", 32'(ce_count_o), 32'd0);
        check("rst_run_mode", 32'(run_mode_o), 32'd0);
        run_i = 1'b0; step_btn_i = 1'b0;
        cycles(2);
        rst_n = 1'b1;

        // counter wrap, then async reset mid-pulse
        saw_wrap = 1'b0;
        run_i = 1'b1;
        cycles(80);
        check("wrap_seen", 32'(saw_wrap), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            if (cpu_ce_o) break;
        end
        check("ce_for_async_rst", 32'(cpu_ce_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_ce", 32'(cpu_ce_o), 32'd0);
        check("async_rst_count", 32'(ce_count_o), 32'd0);
        cycles(2);
        rst_n = 1'b1;
        run_i = 1'b0;
        cycles(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Sits directly downstream of the parameterised clock divider. Consumes its divided clock level and produces a single-cycle CPU clock-enable pulse in the fast clk domain.
- Supports free-run mode, debounced single-step mode and a sticky HLT stop.
- The SAP-3 core registers advance only on cpu_ce_o, so the whole design stays on one clock.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required before step_btn_i changes its debounced level; must be ≥2.
- CE_CNT_W, 16: width of the issued-enable counter.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- div_clk_i, input, 1: divided clock level from the divider; registered in the clk domain.
- run_i, input, 1: mode switch, 1 = free-run, 0 = single-step; asynchronous.
- step_btn_i, input, 1: raw step pushbutton, active-high, asynchronous, bouncy.
- hlt_i, input, 1: CPU decoded HLT; synchronous, level.
- cpu_ce_o, output, 1: one-clk-cycle CPU clock-enable pulse.
- halted_o, output, 1: block is in HALTED.
- run_mode_o, output, 1: block is in RUN.
- step_pending_o, output, 1: a debounced step press is armed and waiting for a tick.
- ce_count_o, output, CE_CNT_W: number of cpu_ce_o pulses issued; wraps.

Behaviour:
- Reset: all outputs are 0, state is STEP_IDLE, all synchronisers and the debounce counter are 0.
- Tick: tick = div_clk_i & ~div_clk_q, where div_clk_q is div_clk_i delayed one clk. Tick is high in the first cycle div_clk_i is seen high. div_clk_i is not synchronised.
- run_i: passes through a 2-flop synchroniser, giving run_s.
- step_btn_i: 2-flop synchroniser, then debounce.
  - Debounce counter resets whenever the synchronised level equals btn_db or changes.
  - btn_db takes the new level after DEBOUNCE_CYCLES consecutive equal differing samples.
  - press = rising edge of btn_db, one cycle wide.
- cpu_ce_o is registered: it pulses in the cycle after the qualifying tick. Latency tick→ce is 1 cycle. It is never high two consecutive cycles.
- ce_count_o increments in the same cycle cpu_ce_o is high, wrapping from all-ones to 0.
- States:
  - STEP_IDLE
    - run_s=1 → RUN.
    - Else, if press → STEP_ARMED.
    - Ticks are ignored.
  - STEP_ARMED (step_pending_o=1)
    - run_s=1 → RUN; the armed step is discarded and no ce is issued.
    - Else, if tick → issue ce and go to STEP_IDLE.
    - Further presses while armed are ignored; a step is never queued twice.
  - RUN (run_mode_o=1)
    - Every tick issues ce.
    - run_s=0 → STEP_IDLE. A tick in that same cycle is dropped.
    - Presses are ignored.
  - HALTED (halted_o=1)
    - No ce is issued.
    - Ticks, presses and run_s are ignored.
    - The only exit is rst_n.
- hlt_i=1 in any state forces → HALTED next cycle. It has priority over tick, press and run_s in the same cycle: a ce that would have been issued from that cycle's tick is suppressed.
- Reset mid-operation: a ce pulse in flight is cleared immediately (asynchronous reset). The debounce state is lost, so the button must be re-debounced after reset.
- step_btn_i held across entry to STEP_IDLE: no press is generated until btn_db falls and rises again.

Decomposition:
- Package sap3_clk_pkg:
  - typedef enum logic [1:0] clk_state_t {STEP_IDLE, STEP_ARMED, RUN, HALTED}.
  - Default constants DEBOUNCE_CYCLES_DEF=16 and CE_CNT_W_DEF=16.
- One sub-module, btn_debounce: 2-flop synchroniser, debounce counter and rising-edge press pulse, parameterised by DEBOUNCE_CYCLES.
- The FSM, tick detector, run synchroniser and counter stay in cpu_clk_ctrl.

Test Plan:
All scenarios use a bench with DEBOUNCE_CYCLES=4 and a divider with DIVIDE_BY=4, so div_clk_i has a 4-cycle period and tick occurs every 4 clk.
- Run mode: hold run_i=1 from reset for 40 cycles → run_mode_o=1 by cycle 3; cpu_ce_o pulses exactly 1 cycle after each tick, every 4 cycles; ce_count_o = number of pulses; no ce before RUN is entered.
- Single step with bounce: run_i=0; toggle step_btn_i 1/0/1 at 1-cycle intervals, then hold 1 for 10 cycles → exactly one press, step_pending_o=1 until the next tick, then one cpu_ce_o; ce_count_o=1. Release and press again → ce_count_o=2.
- Double press while armed: a second debounced press before the tick → still a single cpu_ce_o; ce_count_o increments by 1.
- HLT priority: in RUN, assert hlt_i in the same cycle as a tick → no ce the following cycle; halted_o=1. Over 20 further cycles with run_i and step presses toggling, ce_count_o is unchanged. Pulse rst_n → all outputs 0, STEP_IDLE.
- Mode switch: in STEP_ARMED, raise run_i → after synchronisation, RUN with step_pending_o=0 and no extra ce. Drop run_i coincident with a tick → that tick produces no ce; state is STEP_IDLE.
- Counter wrap and async reset: force CE_CNT_W=4, run for 17 ce pulses → ce_count_o goes 15→0→1. Assert rst_n low mid-pulse → cpu_ce_o falls immediately.
